// File: rtl/cabac_se_pkg.sv
// Shared definitions for the CABAC mvd/mvp syntax-element serializer:
// pair layout, emission order, FSM encoding and context indices.
package cabac_se_pkg;

    localparam int unsigned SE_W  = 23;
    localparam int unsigned MVP_W = 15;
    localparam int unsigned N_ENT = 9;
    localparam int unsigned IDX_W = 4;

    typedef struct packed {
        logic [9:0] value;
        logic [3:0] bin_type;
        logic [8:0] ctx;
    } se_pair_t;

    // mvd_coding() order: gt0 x/y, gt1 x/y, minus2 x, sign x, minus2 y, sign y, mvp flag
    localparam logic [IDX_W-1:0] EMIT_ORDER [N_ENT] = '{
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd5, 4'd7, 4'd8
    };

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [8:0] CTX_GT0    = 9'h016;
    localparam logic [8:0] CTX_GT1    = 9'h017;
    localparam logic [8:0] CTX_MINUS2 = 9'h0BE;
    localparam logic [8:0] CTX_SIGN   = 9'h0BB;
    localparam logic [8:0] CTX_MVP    = 9'h0B0;

endpackage

// File: rtl/cabac_se_pick9.sv
// Combinational priority pick: first set mask bit in emission order.
module cabac_se_pick9
    import cabac_se_pkg::*;
(
    input  logic [N_ENT-1:0] mask_i,
    output logic [IDX_W-1:0] idx_c_o,
    output logic             any_c_o
);

    // Walk from the last position back so the earliest set position wins.
    always_comb begin
        idx_c_o = '0;
        any_c_o = 1'b0;
        for (int p = int'(N_ENT) - 1; p >= 0; p--) begin
            if (mask_i[EMIT_ORDER[p]]) begin
                idx_c_o = EMIT_ORDER[p];
                any_c_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cabac_se_mvd_serializer.sv
// Captures the nine mvd/mvp se-pairs of one PU and issues the non-empty ones
// one per cycle, in mvd_coding() order, over a valid/ready handshake.
module cabac_se_mvd_serializer
    import cabac_se_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              mvp_en_i,
    input  logic [SE_W-1:0]   se_pair_mv_0_i,
    input  logic [SE_W-1:0]   se_pair_mv_1_i,
    input  logic [SE_W-1:0]   se_pair_mv_2_i,
    input  logic [SE_W-1:0]   se_pair_mv_3_i,
    input  logic [SE_W-1:0]   se_pair_mv_4_i,
    input  logic [SE_W-1:0]   se_pair_mv_5_i,
    input  logic [SE_W-1:0]   se_pair_mv_6_i,
    input  logic [SE_W-1:0]   se_pair_mv_7_i,
    input  logic [MVP_W-1:0]  se_pair_mv_8_i,
    output logic [SE_W-1:0]   se_pair_o,
    output logic              se_valid_o,
    input  logic              se_ready_i,
    output logic              busy_o,
    output logic              done_o
);

    logic [1:0]       state_q, state_d;
    logic [N_ENT-1:0] mask_q, mask_d;
    logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
    se_pair_t         pair_q, pair_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    se_pair_t         ent_q [N_ENT];
    se_pair_t         in_c  [N_ENT];
    logic [N_ENT-1:0] in_mask_c;
    logic [N_ENT-1:0] cur_oh_c;
    logic [N_ENT-1:0] pick_mask_c;
    logic [IDX_W-1:0] pick_idx_c;
    logic             pick_any_c;
    logic             cap_c;

    // Input gather; the mvp pair is narrower and zero-extended.
    always_comb begin
        in_c[0] = se_pair_t'(se_pair_mv_0_i);
        in_c[1] = se_pair_t'(se_pair_mv_1_i);
        in_c[2] = se_pair_t'(se_pair_mv_2_i);
        in_c[3] = se_pair_t'(se_pair_mv_3_i);
        in_c[4] = se_pair_t'(se_pair_mv_4_i);
        in_c[5] = se_pair_t'(se_pair_mv_5_i);
        in_c[6] = se_pair_t'(se_pair_mv_6_i);
        in_c[7] = se_pair_t'(se_pair_mv_7_i);
        in_c[8] = se_pair_t'(SE_W'(se_pair_mv_8_i));
    end

    always_comb begin
        in_mask_c = '0;
        for (int i = 0; i < int'(N_ENT); i++) begin
            in_mask_c[i] = (in_c[i] != '0);
        end
        in_mask_c[N_ENT-1] = in_mask_c[N_ENT-1] & mvp_en_i;
    end

    // In SEND the picker looks ahead past the entry being accepted, so the
    // next pair is ready in the same cycle.
    assign cur_oh_c    = N_ENT'(1) << cur_idx_q;
    assign pick_mask_c = (state_q == ST_SEND) ? (mask_q & ~cur_oh_c) : mask_q;

    cabac_se_pick9 u_pick (
        .mask_i  (pick_mask_c),
        .idx_c_o (pick_idx_c),
        .any_c_o (pick_any_c)
    );

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        cur_idx_d = cur_idx_q;
        pair_d    = pair_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cap_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    cap_c   = 1'b1;
                    mask_d  = in_mask_c;
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (pick_any_c) begin
                    pair_d    = ent_q[pick_idx_c];
                    cur_idx_d = pick_idx_c;
                    valid_d   = 1'b1;
                    state_d   = ST_SEND;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_SEND: begin
                if (valid_q && se_ready_i) begin
                    mask_d = pick_mask_c;
                    if (pick_any_c) begin
                        pair_d    = ent_q[pick_idx_c];
                        cur_idx_d = pick_idx_c;
                    end else begin
                        pair_d  = '0;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mask_q    <= '0;
            cur_idx_q <= '0;
            pair_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            cur_idx_q <= cur_idx_d;
            pair_q    <= pair_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Entry store, written only when a new PU is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_ENT); i++) begin
                ent_q[i] <= '0;
            end
        end else if (cap_c) begin
            for (int i = 0; i < int'(N_ENT); i++) begin
                ent_q[i] <= in_c[i];
            end
        end
    end

    assign se_pair_o  = pair_q;
    assign se_valid_o = valid_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_cabac_se_mvd_serializer.sv
// Bench for cabac_se_mvd_serializer: table vectors, corner sequences and
// random PUs checked against an mv-level reference model.
`timescale 1ns/1ps
module tb_cabac_se_mvd_serializer;
    import cabac_se_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0;
    logic              mvp_en_i = 1'b0;
    logic              se_ready_i = 1'b0;
    logic [SE_W-1:0]   mv [8];
    logic [MVP_W-1:0]  mv8;
    logic [SE_W-1:0]   se_pair_o;
    logic              se_valid_o, busy_o, done_o;

    cabac_se_mvd_serializer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .mvp_en_i       (mvp_en_i),
        .se_pair_mv_0_i (mv[0]),
        .se_pair_mv_1_i (mv[1]),
        .se_pair_mv_2_i (mv[2]),
        .se_pair_mv_3_i (mv[3]),
        .se_pair_mv_4_i (mv[4]),
        .se_pair_mv_5_i (mv[5]),
        .se_pair_mv_6_i (mv[6]),
        .se_pair_mv_7_i (mv[7]),
        .se_pair_mv_8_i (mv8),
        .se_pair_o      (se_pair_o),
        .se_valid_o     (se_valid_o),
        .se_ready_i     (se_ready_i),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [SE_W-1:0] ent [9];
    logic [SE_W-1:0] got_q [$];
    logic [SE_W-1:0] exp_q [$];
    int n_done, done_c, first_c;

    typedef struct {
        int mx; int my; int idx; bit en; int rdy; int inj; int exp_n;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [SE_W-1:0] w(input int v, input int bt, input logic [8:0] ctx);
        return {10'(v), 4'(bt), ctx};
    endfunction

    // Syntax elements of mvd_coding() for one motion vector difference.
    task automatic build(input int mx, input int my, input int idx);
        int ax, ay;
        ax = (mx < 0) ? -mx : mx;
        ay = (my < 0) ? -my : my;
        ent[0] = w(int'(ax > 0), 1, CTX_GT0);
        ent[1] = w(int'(ay > 0), 1, CTX_GT0);
        ent[2] = (ax > 0) ? w(int'(ax > 1), 1, CTX_GT1) : '0;
        ent[3] = (ay > 0) ? w(int'(ay > 1), 1, CTX_GT1) : '0;
        ent[4] = (ax > 1) ? w(ax - 2, 2, CTX_MINUS2) : '0;
        ent[5] = (ay > 1) ? w(ay - 2, 2, CTX_MINUS2) : '0;
        ent[6] = (mx != 0) ? w(int'(mx < 0), 1, CTX_SIGN) : '0;
        ent[7] = (my != 0) ? w(int'(my < 0), 1, CTX_SIGN) : '0;
        ent[8] = w(idx, 1, CTX_MVP);
    endtask

    // Expected stream: present entries in coding order, mvp only if enabled.
    task automatic model(input bit en);
        int ord [9];
        ord = '{0, 1, 2, 3, 4, 6, 5, 7, 8};
        exp_q.delete();
        for (int k = 0; k < 9; k++) begin
            if (ent[ord[k]] != '0 && (ord[k] != 8 || en)) exp_q.push_back(ent[ord[k]]);
        end
    endtask

    function automatic logic [SE_W-1:0] got_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 'x;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < 8; i++) mv[i] = ent[i];
        mv8 = ent[8][14:0];
    endtask

    task automatic scramble();
        for (int i = 0; i < 8; i++) mv[i] = SE_W'($urandom());
        mv8 = MVP_W'($urandom());
    endtask

    // One PU from start pulse to the cycle after done; c counts cycles after T.
    task automatic run_pu(input bit en, input int rdy, input int inject_at);
        logic [SE_W-1:0] prev;
        bit stalled;
        int c;
        got_q.delete();
        n_done = 0; done_c = -1; first_c = -1;
        stalled = 1'b0; prev = '0;
        @(negedge clk);
        drive_inputs();
        mvp_en_i = en; start_i = 1'b1; se_ready_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        scramble();
        c = 1;
        chk("busy_after_start", busy_o, 1);
        chk("no_valid_in_load", se_valid_o, 0);
        while (c < 300) begin
            if (stalled) begin
                chk("stall_hold_pair", se_pair_o, prev);
                chk("stall_hold_valid", se_valid_o, 1);
            end
            if (se_valid_o && first_c < 0) first_c = c;
            if (done_o) begin
                n_done++;
                done_c = c;
                chk("busy_at_done", busy_o, 1);
            end
            if (done_c >= 0 && c == done_c + 1) begin
                chk("busy_after_done", busy_o, 0);
                break;
            end
            if (c == inject_at) begin
                scramble();
                mvp_en_i = ~en;
                start_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            se_ready_i = (int'($urandom_range(99)) < rdy);
            if (se_valid_o && se_ready_i) got_q.push_back(se_pair_o);
            stalled = se_valid_o && !se_ready_i;
            prev = se_pair_o;
            @(negedge clk);
            c++;
        end
        se_ready_i = 1'b0;
        start_i = 1'b0;
    endtask

    task automatic compare(input string tag, input bit en, input int exp_n, input int rdy);
        model(en);
        if (exp_n >= 0) chk({tag, " model_count"}, exp_q.size(), exp_n);
        chk({tag, " count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s pair%0d", tag, i), got_at(i), exp_q[i]);
        chk({tag, " done_pulses"}, n_done, 1);
        chk({tag, " first_valid_cycle"}, first_c, 2);
        if (rdy == 100) chk({tag, " done_cycle"}, done_c, exp_q.size() + 2);
    endtask

    initial begin
        int acc, mx, my, idx, rdy, inj;
        bit en;

        tbl[0] = '{0, 0, 0, 1'b1, 100, -1, 3};
        tbl[1] = '{1, 0, 1, 1'b1, 100, -1, 5};
        tbl[2] = '{-5, 3, 0, 1'b0, 100, -1, 8};
        tbl[3] = '{-7, -9, 1, 1'b1, 100, -1, 9};
        tbl[4] = '{-7, -9, 1, 1'b1, 50, -1, 9};
        tbl[5] = '{2, -1, 1, 1'b0, 100, 3, 7};

        scramble();
        repeat (3) @(negedge clk);
        chk("reset_valid", se_valid_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        chk("reset_pair", se_pair_o, 0);
        rst_n = 1'b1;

        for (int t = 0; t < 6; t++) begin
            build(tbl[t].mx, tbl[t].my, tbl[t].idx);
            run_pu(tbl[t].en, tbl[t].rdy, tbl[t].inj);
            compare($sformatf("vec%0d", t), tbl[t].en, tbl[t].exp_n, tbl[t].rdy);
            if (t == 0) begin
                chk("zero_mv w0", got_at(0), 23'h000216);
                chk("zero_mv w1", got_at(1), 23'h000216);
                chk("zero_mv w2", got_at(2), 23'h0002B0);
            end
            if (t == 1) begin
                chk("x1 w0", got_at(0), 23'h002216);
                chk("x1 w1", got_at(1), 23'h000216);
                chk("x1 w2", got_at(2), 23'h000217);
                chk("x1 w3", got_at(3), 23'h0002BB);
                chk("x1 w4", got_at(4), 23'h0022B0);
            end
            if (t == 2) begin
                chk("m5p3 minus2_x", 32'(got_at(4) >> 13), 3);
                chk("m5p3 sign_x", 32'(got_at(5) >> 13), 1);
                chk("m5p3 minus2_y", 32'(got_at(6) >> 13), 1);
                chk("m5p3 sign_y", 32'(got_at(7) >> 13), 0);
                for (int i = 0; i < got_q.size(); i++)
                    chk($sformatf("m5p3 no_mvp%0d", i), 32'(got_q[i][8:0] == CTX_MVP), 0);
            end
        end

        // Reset after the second accepted pair of a 9-pair PU.
        build(-7, -9, 1);
        @(negedge clk);
        drive_inputs();
        mvp_en_i = 1'b1; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; se_ready_i = 1'b1; acc = 0;
        for (int k = 0; k < 20 && acc < 2; k++) begin
            if (se_valid_o) acc++;
            if (acc < 2) @(negedge clk);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", se_valid_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_pair", se_pair_o, 0);
        se_ready_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_done", done_o, 0);
        end
        rst_n = 1'b1;
        run_pu(1'b1, 100, -1);
        compare("post_reset", 1'b1, 9, 100);

        for (int r = 0; r < 20; r++) begin
            mx  = int'($urandom_range(600)) - 300;
            my  = int'($urandom_range(600)) - 300;
            idx = int'($urandom_range(1));
            en  = 1'($urandom_range(1));
            rdy = (r % 3 == 0) ? 100 : ((r % 3 == 1) ? 50 : 30);
            inj = ($urandom_range(3) == 0) ? 3 : -1;
            build(mx, my, idx);
            run_pu(en, rdy, inj);
            compare($sformatf("rand%0d", r), en, -1, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cabac_se_mvd_serializer.md
# cabac_se_mvd_serializer

Sequencer that sits directly downstream of the mvd/mvp syntax-element preparation stage in the CABAC path. It captures the nine parallel se-pair words for one prediction unit and issues them one per cycle to the binarizer / arithmetic-coder input. It skips absent (all-zero) entries, emits the entries in HEVC `mvd_coding()` order, and uses a valid/ready handshake.

## Interface
- `SE_W`, 23: width of one se-pair word, laid out as {value[9:0], bin-type[3:0], ctx[8:0]}.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  one-cycle pulse; capture all pair inputs this cycle.
- `mvp_en_i`  in  1  sampled with `start_i`. When 0, the mvp flag pair (entry 8) is suppressed.
- `se_pair_mv_0_i` … `se_pair_mv_7_i`  in  23 each  mvd pairs from the preparation stage.
- `se_pair_mv_8_i`  in  15  mvp_lx_flag pair. Zero-extended to 23 bits on capture.
- `se_pair_o`  out  23  current pair.
- `se_valid_o`  out  1  `se_pair_o` is valid.
- `se_ready_i`  in  1  consumer accepts the pair when `se_valid_o` and `se_ready_i` are both high.
- `busy_o`  out  1  high from the cycle after `start_i` until `done_o`, inclusive.
- `done_o`  out  1  one-cycle pulse after the last pair is accepted.

## Operation
- Emission order by entry index: 0, 1, 2, 3, 4, 6, 5, 7, 8. This is greater0 x/y, greater1 x/y, minus2 x, sign x, minus2 y, sign y, mvp flag.
- On `start_i` in IDLE:
  - register all nine entries (entry 8 zero-extended);
  - build a 9-bit pending mask with bit i = (entry i != 0);
  - clear bit 8 when `mvp_en_i` = 0.
- FSM states:
  - **IDLE**: `start_i` → LOAD.
  - **LOAD**: select the first pending entry in order → SEND. The mask is never empty, because entries 0 and 1 are always nonzero.
  - **SEND**: hold `se_pair_o` and `se_valid_o` stable until accepted. On accept, clear that mask bit. Then either load the next pending entry in the same cycle (no bubble), or, if the mask is now empty, → DONE.
  - **DONE**: `done_o` = 1 for one cycle → IDLE.
- Next-entry selection: a priority pick over the remapped mask. It takes zero cycles, so skipped entries cost no cycles.
- `start_i` outside IDLE is ignored. Captured data is not disturbed.
- The inputs only need to be stable in the `start_i` cycle.

## Timing
- Reset values: `se_pair_o` = 0, `se_valid_o` = 0, `busy_o` = 0, `done_o` = 0, mask = 0, FSM = IDLE.
- `start_i` at cycle T → first `se_valid_o` at T+2 (capture in T+1, LOAD, output registered).
- With `se_ready_i` held at 1, N pending pairs occupy cycles T+2 … T+N+1, and `done_o` is high at T+N+2.
- Throughput is 1 pair per cycle. The earliest next accepted `start_i` is T+N+3.
- When `se_ready_i` is low, `se_pair_o` and `se_valid_o` hold their values; no pair is dropped or duplicated.
- `rst_n` asserted mid-sequence: all outputs clear immediately. No `done_o` is produced, and the remaining pairs are discarded.
- Pairs per PU range from 3 (both mvd components zero, mvp enabled) to 9.

## Structure
- Shared package `cabac_se_pkg`:
  - `SE_W`;
  - the emission-order constant array {0,1,2,3,4,6,5,7,8};
  - the FSM state encoding;
  - context-index constants 0x16, 0x17, 0x0BE, 0x0BB, 0x0B0 for bench checks.
- One natural sub-module: `cabac_se_pick9`, a combinational priority picker that returns the first set bit of a 9-bit mask in emission order, plus an any-set flag.

## Test plan
- mv = (0,0), `mvp_en_i` = 1, mvp_idx = 0, ready held 1 → exactly 3 pairs in consecutive cycles: 0x000216, 0x000216, 0x0002B0. `done_o` at T+5.
- mv_x = +1, mv_y = 0, mvp_idx = 1 → pairs 0x002216, 0x000216, 0x000217, 0x0002BB, 0x0022B0, in that order.
- mv_x = −5, mv_y = +3, `mvp_en_i` = 0 → 8 pairs in order 0,1,2,3,4,6,5,7. Entry 4 value is 3, entry 5 value is 1, sign x = 1, sign y = 0. No 0x..B0 pair appears.
- Random `se_ready_i` (50 %) on the 9-pair case → output stable while stalled. The accepted sequence equals the ready-always sequence, with exactly one `done_o`.
- `start_i` pulsed during SEND with different data → ignored; the original sequence completes unchanged.
- `rst_n` dropped after the 2nd accept → `se_valid_o` and `busy_o` are 0 immediately. After release, a new `start_i` produces a complete, correct sequence.
